neuron_mac: RTL and testbench
=============================

NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL have parameter N, default 4, meaning the number of weighted inputs per neuron (range 1..255).
REQ-002 SHALL have port iClk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port iRst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 SHALL have port iStart, input, 1 bit: begins a new neuron evaluation when sampled high in IDLE.
REQ-005 SHALL have port iBias, input, 32 bits: signed Q12.20 bias, captured with iStart.
REQ-006 SHALL have port iValid, input, 1 bit: iX/iW pair offered.
REQ-007 SHALL have port iX, input, 8 bits: signed Q3.5 neuron input (8'h20 = 1.0).
REQ-008 SHALL have port iW, input, 16 bits: signed Q1.15 weight (16'h4000 = 0.5).
REQ-009 SHALL have port oReady, output, 1 bit: the block accepts a pair this cycle.
REQ-010 SHALL have port oAcc, output, 32 bits: signed Q12.20 weighted sum, fed directly to the activation stage iA.
REQ-011 SHALL have port oDone, output, 1 bit: one-cycle pulse marking oAcc final.
REQ-012 SHALL have port oBusy, output, 1 bit: high in ACC and DONE states.
REQ-013 SHALL have port oOvf, output, 1 bit: sticky saturation flag for the current evaluation.

Function
REQ-014 SHALL implement the states IDLE, ACC and DONE, with all outputs driven from registers or decoded from the state only.
REQ-015 In IDLE, iStart=1 SHALL load acc<=iBias, cnt<=0 and oOvf<=0, and go to ACC; iStart outside IDLE SHALL be ignored.
REQ-016 oReady SHALL be 1 exactly when the state is ACC, and a pair SHALL be accepted only on a cycle with iValid=1 and oReady=1.
REQ-017 Each accepted pair SHALL compute a product p = iX*iW as a signed 24-bit Q4.20 value, sign-extended to 32 bits.
REQ-018 The update SHALL be acc <= sat32(acc + p), computed with a 33-bit signed sum.
REQ-019 On positive overflow the result SHALL clamp to 32'h7FFFFFFF, on negative overflow it SHALL clamp to 32'h80000000, and either clamp SHALL set oOvf<=1.
REQ-020 Each accepted pair SHALL increment cnt.
REQ-021 The acceptance that occurs when cnt==N-1 SHALL move the state to DONE.
REQ-022 DONE SHALL last exactly one cycle with oDone=1, then the state SHALL return to IDLE.
REQ-023 Latency SHALL be that oDone rises the cycle after the Nth acceptance edge, with oAcc already final in that cycle.
REQ-024 oAcc SHALL equal acc at all times and SHALL hold its value in IDLE until the next iStart.
REQ-025 iValid=1 outside ACC SHALL be ignored, with no count change and no accumulation.
REQ-026 Gaps in iValid during ACC SHALL stall the block with acc and cnt held.
REQ-027 With N=1, one acceptance SHALL go ACC->DONE.
REQ-028 iStart=1 during the DONE cycle SHALL be ignored; iStart in the following IDLE cycle SHALL be honoured.

Reset
REQ-029 iRst_n=0 SHALL force, asynchronously, state=IDLE, acc=0, cnt=0, oAcc=0, oReady=0, oDone=0, oBusy=0 and oOvf=0.
REQ-030 A reset asserted mid-evaluation SHALL abort the evaluation with no oDone pulse.
REQ-031 After reset release, the first iStart SHALL be honoured on the first rising edge.

Verification
REQ-032 The bench SHALL cover: N=4, iBias=0, four pairs iX=8'h20, iW=16'h4000 -> oAcc=32'h00200000 (2.0) with oDone one cycle after the 4th accept, and oOvf=0.
REQ-033 The bench SHALL cover: N=4, iBias=0, four pairs iX=8'hE0, iW=16'h4000 -> oAcc=32'hFFE00000 (-2.0), oOvf=0.
REQ-034 The bench SHALL cover: iBias=32'h7FFFFFFF, pairs iX=8'h7F, iW=16'h7FFF -> oAcc=32'h7FFFFFFF and oOvf=1 after the 1st accept, both holding through oDone.
REQ-035 The bench SHALL cover: iValid toggling 1,0,0,1,1,0,1 with iX=8'h20, iW=16'h4000 -> exactly 4 accepts, oAcc=32'h00200000, oDone 1 cycle after the last accept.
REQ-036 The bench SHALL cover: iRst_n pulsed low after 2 accepts -> all outputs 0 immediately, no oDone, and a fresh iStart with iBias=32'h00100000 plus 4 pairs (8'h20,16'h4000) -> oAcc=32'h00300000.
REQ-037 The bench SHALL cover: iStart and iValid asserted during ACC and DONE -> acc, cnt and state unaffected by iStart, and iValid ignored in DONE and IDLE.

Source files
------------

// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
// Module   : neuron_mac
// Purpose  : Multiply-accumulate core for one neuron. It starts from a Q12.20
//            bias and adds N products of a Q3.5 input and a Q1.15 weight. The
//            32-bit running sum saturates, and a sticky flag records any
//            saturation.
// Revision : 1.0 - initial release
//
// Ports
//   iClk    in   1   clock; all state changes on the rising edge
//   iRst_n  in   1   asynchronous active-low reset
//   iStart  in   1   begin an evaluation (honoured in IDLE only)
//   iBias   in  32   signed Q12.20 bias, captured with iStart
//   iValid  in   1   iX/iW pair offered
//   iX      in   8   signed Q3.5 input
//   iW      in  16   signed Q1.15 weight
//   oReady  out  1   a pair is accepted this cycle if iValid is high (ACC)
//   oAcc    out 32   signed Q12.20 accumulator
//   oDone   out  1   one-cycle pulse, oAcc final
//   oBusy   out  1   high in ACC and DONE
//   oOvf    out  1   sticky saturation flag for the current evaluation
// ============================================================================
module neuron_mac #(
  parameter int N = 4
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iStart,
  input  logic [31:0] iBias,
  input  logic        iValid,
  input  logic [7:0]  iX,
  input  logic [15:0] iW,
  output logic        oReady,
  output logic [31:0] oAcc,
  output logic        oDone,
  output logic        oBusy,
  output logic        oOvf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] C_LAST = 8'(N - 1);

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_acc;
  logic [7:0]         r_cnt;
  logic               r_ovf;

  logic               w_accept;
  logic signed [23:0] w_prod;
  logic [32:0]        w_sum;
  logic               w_pos_ovf;
  logic               w_neg_ovf;
  logic [31:0]        w_sat;

  assign w_accept = (r_state == S_ACC) && iValid;

  // Q3.5 x Q1.15 gives Q4.20, which lines up with the Q12.20 accumulator.
  assign w_prod = $signed(iX) * $signed(iW);

  // A 33-bit sum keeps the true result. Bits 32 and 31 differ only on overflow.
  assign w_sum     = {r_acc[31], r_acc} + {{9{w_prod[23]}}, w_prod};
  assign w_pos_ovf = (w_sum[32:31] == 2'b01);
  assign w_neg_ovf = (w_sum[32:31] == 2'b10);

  always_comb begin
    w_sat = w_sum[31:0];
    if (w_pos_ovf) begin
      w_sat = 32'h7FFF_FFFF;
    end else if (w_neg_ovf) begin
      w_sat = 32'h8000_0000;
    end
  end

  // State register
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (iStart) begin
          w_next = S_ACC;
        end
      end
      S_ACC: begin
        if (w_accept && (r_cnt == C_LAST)) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: the accumulator, the pair counter and the sticky overflow flag
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_acc <= 32'd0;
      r_cnt <= 8'd0;
      r_ovf <= 1'b0;
    end else if ((r_state == S_IDLE) && iStart) begin
      r_acc <= iBias;
      r_cnt <= 8'd0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sat;
      r_cnt <= r_cnt + 8'd1;
      if (w_pos_ovf || w_neg_ovf) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign oAcc   = r_acc;
  assign oOvf   = r_ovf;
  assign oReady = (r_state == S_ACC);
  assign oDone  = (r_state == S_DONE);
  assign oBusy  = (r_state == S_ACC) || (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_mac
// Purpose  : Directed self-checking bench for neuron_mac with N=4. It drives
//            inputs 1 ns after each rising edge and checks outputs in that
//            same slot.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_mac;

  logic        iClk;
  logic        iRst_n;
  logic        iStart;
  logic [31:0] iBias;
  logic        iValid;
  logic [7:0]  iX;
  logic [15:0] iW;
  logic        oReady;
  logic [31:0] oAcc;
  logic        oDone;
  logic        oBusy;
  logic        oOvf;

  int n_tests;
  int n_fail;

  neuron_mac #(.N(4)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iStart (iStart),
    .iBias  (iBias),
    .iValid (iValid),
    .iX     (iX),
    .iW     (iW),
    .oReady (oReady),
    .oAcc   (oAcc),
    .oDone  (oDone),
    .oBusy  (oBusy),
    .oOvf   (oOvf)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Status outputs packed as {oReady, oBusy, oDone, oOvf}
  task automatic chk_st(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, oReady, oBusy, oDone, oOvf}, {28'd0, exp});
  endtask

  task automatic tick;
    @(posedge iClk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    iRst_n  = 1'b0;
    iStart  = 1'b0;
    iBias   = 32'd0;
    iValid  = 1'b0;
    iX      = 8'h00;
    iW      = 16'h0000;

    // Reset state
    #2;
    chk("rst_acc", oAcc, 32'd0);
    chk_st("rst_status", 4'b0000);
    #10;
    iRst_n = 1'b1;

    // 4 x (1.0 * 0.5) = 2.0. The start is taken on the first edge after release.
    iStart = 1'b1;
    iBias  = 32'd0;
    tick;
    chk("t1_start_acc", oAcc, 32'd0);
    chk_st("t1_start_status", 4'b1100);
    iStart = 1'b0;
    iValid = 1'b1;
    iX     = 8'h20;
    iW     = 16'h4000;
    tick;
    tick;
    tick;
    chk("t1_acc3", oAcc, 32'h0018_0000);
    chk_st("t1_acc3_status", 4'b1100);
    tick;
    chk("t1_final_acc", oAcc, 32'h0020_0000);
    chk_st("t1_done_status", 4'b0110);
    tick;  // iValid still high while in IDLE, so nothing is accepted
    chk("t1_idle_hold", oAcc, 32'h0020_0000);
    chk_st("t1_idle_status", 4'b0000);
    tick;
    chk("t1_idle_hold2", oAcc, 32'h0020_0000);

    // 4 x (-1.0 * 0.5) = -2.0
    iValid = 1'b0;
    iStart = 1'b1;
    iBias  = 32'd0;
    tick;
    iStart = 1'b0;
    iValid = 1'b1;
    iX     = 8'hE0;
    iW     = 16'h4000;
    repeat (4) tick;
    chk("t2_final_acc", oAcc, 32'hFFE0_0000);
    chk_st("t2_done_status", 4'b0110);

    // Positive saturation from the first accept onward
    iValid = 1'b0;
    tick;
    iStart = 1'b1;
    iBias  = 32'h7FFF_FFFF;
    tick;
    chk("t3_bias", oAcc, 32'h7FFF_FFFF);
    chk_st("t3_start_status", 4'b1100);
    iStart = 1'b0;
    iValid = 1'b1;
    iX     = 8'h7F;
    iW     = 16'h7FFF;
    tick;
    chk("t3_acc1", oAcc, 32'h7FFF_FFFF);
    chk_st("t3_acc1_status", 4'b1101);
    repeat (3) tick;
    chk("t3_final_acc", oAcc, 32'h7FFF_FFFF);
    chk_st("t3_done_status", 4'b0111);

    // Negative saturation. The next start also clears oOvf.
    iValid = 1'b0;
    tick;
    iStart = 1'b1;
    iBias  = 32'h8000_0000;
    tick;
    chk_st("t3n_start_ovf_cleared", 4'b1100);
    iStart = 1'b0;
    iValid = 1'b1;
    iX     = 8'h80;
    iW     = 16'h7FFF;
    tick;
    chk("t3n_acc1", oAcc, 32'h8000_0000);
    chk_st("t3n_acc1_status", 4'b1101);
    iValid = 1'b0;
    iX     = 8'h20;
    iW     = 16'h4000;
    repeat (3) begin
      iValid = 1'b1;
      tick;
    end
    chk("t3n_final_acc", oAcc, 32'h8018_0000);
    chk_st("t3n_done_status", 4'b0111);

    // iValid pattern 1,0,0,1,1,0,1 gives exactly four accepts
    iValid = 1'b0;
    tick;
    iStart = 1'b1;
    iBias  = 32'd0;
    tick;
    iStart = 1'b0;
    iX     = 8'h20;
    iW     = 16'h4000;
    iValid = 1'b1; tick;
    chk("t4_v0", oAcc, 32'h0008_0000);
    iValid = 1'b0; tick;
    iValid = 1'b0; tick;
    chk("t4_stall", oAcc, 32'h0008_0000);
    chk_st("t4_stall_status", 4'b1100);
    iValid = 1'b1; tick;
    iValid = 1'b1; tick;
    chk("t4_v4", oAcc, 32'h0018_0000);
    iValid = 1'b0; tick;
    chk_st("t4_stall2_status", 4'b1100);
    iValid = 1'b1; tick;
    chk("t4_final_acc", oAcc, 32'h0020_0000);
    chk_st("t4_done_status", 4'b0110);
    iValid = 1'b0;
    tick;
    chk_st("t4_idle_status", 4'b0000);

    // Reset after two accepts, then a clean evaluation with a bias
    iStart = 1'b1;
    iBias  = 32'h0000_1234;
    tick;
    iStart = 1'b0;
    iValid = 1'b1;
    tick;
    tick;
    iValid = 1'b0;
    chk("t5_pre_rst_acc", oAcc, 32'h0010_1234);
    #2;
    iRst_n = 1'b0;
    #1;
    chk("t5_rst_acc", oAcc, 32'd0);
    chk_st("t5_rst_status", 4'b0000);
    #2;
    iRst_n = 1'b1;
    tick;
    chk_st("t5_no_done1", 4'b0000);
    tick;
    chk_st("t5_no_done2", 4'b0000);
    iStart = 1'b1;
    iBias  = 32'h0010_0000;
    tick;
    iStart = 1'b0;
    iValid = 1'b1;
    repeat (4) tick;
    chk("t5_final_acc", oAcc, 32'h0030_0000);
    chk_st("t5_done_status", 4'b0110);

    // iStart is ignored in ACC and DONE and honoured in the following IDLE.
    // iValid is ignored in DONE.
    iValid = 1'b0;
    tick;
    iStart = 1'b1;
    iBias  = 32'd0;
    tick;
    iBias  = 32'h0555_0000;
    iValid = 1'b1;
    tick;
    chk("t6_start_in_acc_acc", oAcc, 32'h0008_0000);
    chk_st("t6_start_in_acc_status", 4'b1100);
    tick;
    tick;
    tick;
    chk("t6_done_acc", oAcc, 32'h0020_0000);
    chk_st("t6_done_status", 4'b0110);
    tick;  // DONE edge with iStart and iValid high
    chk("t6_after_done_acc", oAcc, 32'h0020_0000);
    chk_st("t6_after_done_status", 4'b0000);
    tick;  // IDLE edge with iStart high
    chk("t6_restart_acc", oAcc, 32'h0555_0000);
    chk_st("t6_restart_status", 4'b1100);
    iStart = 1'b0;
    iValid = 1'b0;
    tick;
    chk("t6_restart_hold", oAcc, 32'h0555_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
